mem_arbiter: RTL and testbench

- Shares the single-port data RAM between two masters: the CPU load/store path and a debug/loader port used for program load and memory dump.
- Sequences every access through a fixed 4-state handshake.
- Produces a stall that freezes the CPU PC while a CPU access is outstanding.
- Sits between the CPU datapath (ALU address, regfile write data, MemRead/MemWrite) and the RAM.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types and constants for the data-RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Access sequencing states; every access walks all four in order.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Current RAM owner, encoded as seen on the owner output.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DBG  = 2'b10
    } owner_t;

    // Width of the debug starvation counter (covers MAX_WAIT up to 15).
    localparam int WAIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pick
//  Brief    : Combinational winner selection between CPU and debug requests
//             with a starvation counter that forces a debug win after
//             MAX_WAIT consecutive losses.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              cpu_req_i,
    input  logic              dbg_req_i,
    input  logic [WAIT_W-1:0] wait_cnt_i,
    output owner_t            grant_o,
    output logic [WAIT_W-1:0] wait_cnt_o
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // CPU has priority until debug has lost MAX_WAIT times in a row; the
    // counter is cleared whenever debug is not contending or wins.
    always_comb begin
        grant_o    = OWN_NONE;
        wait_cnt_o = '0;
        if (cpu_req_i && dbg_req_i) begin
            if (wait_cnt_i < MAX_WAIT_C) begin
                grant_o    = OWN_CPU;
                wait_cnt_o = wait_cnt_i + WAIT_W'(1);
            end else begin
                grant_o    = OWN_DBG;
            end
        end else if (cpu_req_i) begin
            grant_o = OWN_CPU;
        end else if (dbg_req_i) begin
            grant_o = OWN_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares the single-port data RAM between the CPU load/store path
//             and the debug/loader port. Every access takes IDLE->ISSUE->
//             WAIT->DONE; all outputs except cpu_stall are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int MAX_WAIT  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    output logic [31:0]                  cpu_rdata,
    output logic                         cpu_done,
    output logic                         cpu_err,
    output logic                         cpu_stall,
    input  logic                         dbg_req,
    input  logic                         dbg_we,
    input  logic [31:0]                  dbg_addr,
    input  logic [31:0]                  dbg_wdata,
    output logic [31:0]                  dbg_rdata,
    output logic                         dbg_done,
    output logic                         dbg_err,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    output logic                         ram_re,
    output logic                         ram_we,
    input  logic [31:0]                  ram_rdata,
    output logic [1:0]                   owner
);

    localparam int ADDR_W = $clog2(RAM_DEPTH);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic                ram_re_q, ram_re_d;
    logic                ram_we_q, ram_we_d;
    logic [31:0]         cpu_rdata_q, cpu_rdata_d;
    logic [31:0]         dbg_rdata_q, dbg_rdata_d;
    logic                cpu_done_q, cpu_done_d;
    logic                dbg_done_q, dbg_done_d;
    logic                cpu_err_q, cpu_err_d;
    logic                dbg_err_q, dbg_err_d;

    owner_t              w_grant;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_sel_dbg;
    logic                w_sel_we;
    logic [31:0]         w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_sel_err;

    mem_arb_pick #(
        .MAX_WAIT   (MAX_WAIT)
    ) u_pick (
        .cpu_req_i  (cpu_req),
        .dbg_req_i  (dbg_req),
        .wait_cnt_i (wait_q),
        .grant_o    (w_grant),
        .wait_cnt_o (w_wait_nxt)
    );

    // Mux the winning port's fields and reject misaligned or out-of-range
    // byte addresses (anything at or above 4*RAM_DEPTH).
    always_comb begin
        w_sel_dbg   = (w_grant == OWN_DBG);
        w_sel_we    = w_sel_dbg ? dbg_we    : cpu_we;
        w_sel_addr  = w_sel_dbg ? dbg_addr  : cpu_addr;
        w_sel_wdata = w_sel_dbg ? dbg_wdata : cpu_wdata;
        w_sel_err   = (w_sel_addr[1:0] != 2'b00) || (|(w_sel_addr >> (ADDR_W + 2)));
    end

    // Next-state and registered-output logic; pulses default low each cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        err_d       = err_q;
        wait_d      = wait_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_re_d    = 1'b0;
        ram_we_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;
        cpu_err_d   = 1'b0;
        dbg_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                wait_d = w_wait_nxt;
                if (w_grant != OWN_NONE) begin
                    owner_d     = w_grant;
                    we_d        = w_sel_we;
                    err_d       = w_sel_err;
                    ram_addr_d  = w_sel_addr[ADDR_W+1:2];
                    ram_wdata_d = w_sel_wdata;
                    // Strobe registered here so it is visible exactly in ISSUE.
                    ram_re_d    = !w_sel_we && !w_sel_err;
                    ram_we_d    =  w_sel_we && !w_sel_err;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // RAM read data arrives this cycle; route it to the owner only.
                if (!we_q && !err_q) begin
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d = ram_rdata;
                    end else if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = ram_rdata;
                    end
                end
                cpu_done_d = (owner_q == OWN_CPU);
                dbg_done_d = (owner_q == OWN_DBG);
                cpu_err_d  = (owner_q == OWN_CPU) && err_q;
                dbg_err_d  = (owner_q == OWN_DBG) && err_q;
                state_d    = DONE;
            end
            DONE: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
            cpu_err_q   <= cpu_err_d;
            dbg_err_q   <= dbg_err_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_stall = cpu_req & ~cpu_done_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_done  = dbg_done_q;
    assign dbg_err   = dbg_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_re    = ram_re_q;
    assign ram_we    = ram_we_q;
    assign owner     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter with a RAM model, a golden
//             memory image and a randomized transaction sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int RAM_DEPTH = 1024;
    localparam int MAX_WAIT  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
    logic        cpu_done, cpu_err, cpu_stall, dbg_done, dbg_err, ram_re, ram_we;
    logic [9:0]  ram_addr;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    int both_strobe = 0;
    int proto_viol  = 0;
    logic cpu_pend = 1'b0;
    logic dbg_pend = 1'b0;

    logic [31:0] mem  [RAM_DEPTH];
    logic [31:0] gold [RAM_DEPTH];
    bit          gvalid [RAM_DEPTH];

    always #5 clk = ~clk;

    mem_arbiter #(.RAM_DEPTH(RAM_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_err(dbg_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .owner(owner)
    );

    // Synchronous RAM: write on ram_we, read data one cycle after ram_re.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    // Strobe bookkeeping and requester-protocol assertions.
    always @(posedge clk) begin
        if (ram_re || ram_we) strobes <= strobes + 1;
        if (ram_re && ram_we) both_strobe <= both_strobe + 1;
        if (rst_n) begin
            assert (!(cpu_pend && !cpu_req)) else proto_viol <= proto_viol + 1;
            assert (!(dbg_pend && !dbg_req)) else proto_viol <= proto_viol + 1;
        end
        cpu_pend <= rst_n && cpu_req && !cpu_done;
        dbg_pend <= rst_n && dbg_req && !dbg_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one access on a port, hold it until done, then release.
    task automatic run_txn(input bit dbg, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output bit er, output int lat, output bit stall_ok,
                           output logic [1:0] strb_c1, output logic [9:0] addr_c1);
        bit d;
        lat = -1; stall_ok = 1'b1; rd = '0; er = 1'b0; strb_c1 = '0; addr_c1 = '0;
        if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) begin strb_c1 = {ram_re, ram_we}; addr_c1 = ram_addr; end
            d = dbg ? dbg_done : cpu_done;
            if (!dbg && (cpu_stall !== !d)) stall_ok = 1'b0;
            if (d) begin
                lat = c;
                rd  = dbg ? dbg_rdata : cpu_rdata;
                er  = dbg ? dbg_err : cpu_err;
                break;
            end
        end
        @(posedge clk); #1;
        if (dbg) dbg_req = 0; else cpu_req = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0;
        cpu_addr = 0; dbg_addr = 0; cpu_wdata = 0; dbg_wdata = 0;
        @(negedge clk);
        checks++;
        if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
            failures++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dbg_rdata);
        end
        checks++;
        if ({cpu_done, cpu_err, dbg_done, dbg_err, ram_re, ram_we, owner} !== 8'h0) begin
            failures++; $display("FAIL reset_ctrl: got %b want 00000000",
                {cpu_done, cpu_err, dbg_done, dbg_err, ram_re, ram_we, owner});
        end
        checks++;
        if ({ram_addr, ram_wdata} !== 42'h0) begin
            failures++; $display("FAIL reset_ram_bus: got %h/%h want 0/0", ram_addr, ram_wdata);
        end
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({owner, cpu_done, dbg_done, cpu_stall} !== 5'h0) begin
            failures++; $display("FAIL idle_after_reset: got %b want 00000",
                {owner, cpu_done, dbg_done, cpu_stall});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dbg_load();
        logic [31:0] rd; bit er, sok; int lat; logic [1:0] s; logic [9:0] a;
        run_txn(1, 1, 32'h1C, 32'h12345678, rd, er, lat, sok, s, a);
        gold[7] = 32'h12345678; gvalid[7] = 1;
        checks++;
        if (s !== 2'b01 || a !== 10'd7) begin
            failures++; $display("FAIL dbg_store_strobe: got re/we=%b addr=%0d want 01 7", s, a);
        end
        run_txn(1, 0, 32'h1C, 32'h0, rd, er, lat, sok, s, a);
        checks++;
        if (rd !== 32'h12345678 || er !== 1'b0 || lat != 3) begin
            failures++; $display("FAIL dbg_load: got %h err=%b lat=%0d want 12345678 0 3", rd, er, lat);
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            failures++; $display("FAIL dbg_load_cpu_untouched: got %h want 0", cpu_rdata);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; bit er, sok; int lat; logic [1:0] s; logic [9:0] a;
        run_txn(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat, sok, s, a);
        gold[4] = 32'hDEADBEEF; gvalid[4] = 1;
        checks++;
        if (s !== 2'b01 || a !== 10'd4 || lat != 3) begin
            failures++; $display("FAIL cpu_store: got re/we=%b addr=%0d lat=%0d want 01 4 3", s, a, lat);
        end
        run_txn(0, 0, 32'h10, 32'h0, rd, er, lat, sok, s, a);
        checks++;
        if (rd !== 32'hDEADBEEF || lat != 3 || s !== 2'b10) begin
            failures++; $display("FAIL cpu_load: got %h lat=%0d re/we=%b want deadbeef 3 10", rd, lat, s);
        end
        checks++;
        if (sok !== 1'b1) begin
            failures++; $display("FAIL cpu_stall_window: got stall pattern ok=%b want 1", sok);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, c0, d0; bit er, sok; int lat, s0; logic [1:0] s; logic [9:0] a;
        c0 = 32'hDEADBEEF; d0 = 32'h12345678; s0 = strobes;
        run_txn(0, 0, 32'h6, 32'h0, rd, er, lat, sok, s, a);
        checks++;
        if (er !== 1'b1 || lat != 3 || strobes != s0 || cpu_rdata !== c0) begin
            failures++; $display("FAIL err_misaligned: got err=%b lat=%0d strobes=%0d rdata=%h want 1 3 %0d %h",
                er, lat, strobes - s0, cpu_rdata, 0, c0);
        end
        s0 = strobes;
        run_txn(1, 1, 32'h1000, 32'hA5A5A5A5, rd, er, lat, sok, s, a);
        checks++;
        if (er !== 1'b1 || lat != 3 || strobes != s0 || dbg_rdata !== d0) begin
            failures++; $display("FAIL err_out_of_range: got err=%b lat=%0d strobes=%0d rdata=%h want 1 3 %0d %h",
                er, lat, strobes - s0, dbg_rdata, 0, d0);
        end
    endtask

    task automatic test_arbitration();
        int k = 0; bit exp_dbg; bit got_cpu = 0;
        cpu_we = 0; cpu_addr = 32'h10; dbg_we = 0; dbg_addr = 32'h1C;
        cpu_req = 1; dbg_req = 1;
        for (int c = 0; c < 90 && k < 15; c++) begin
            @(negedge clk);
            if (cpu_done || dbg_done) begin
                exp_dbg = ((k % (MAX_WAIT + 1)) == MAX_WAIT);
                checks++;
                if (owner !== (exp_dbg ? 2'b10 : 2'b01) || dbg_done !== exp_dbg || cpu_done !== !exp_dbg) begin
                    failures++; $display("FAIL arb_grant%0d: got owner=%b cpu/dbg=%b%b want owner=%b",
                        k, owner, cpu_done, dbg_done, exp_dbg ? 2'b10 : 2'b01);
                end
                k++;
            end
        end
        checks++;
        if (k != 15) begin
            failures++; $display("FAIL arb_count: got %0d grants want 15", k);
        end
        @(posedge clk); #1 dbg_req = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cpu_done) begin got_cpu = 1; break; end
        end
        checks++;
        if (got_cpu !== 1'b1) begin
            failures++; $display("FAIL arb_tail: got cpu_done=%b want 1", got_cpu);
        end
        @(posedge clk); #1 cpu_req = 0;
    endtask

    task automatic test_back_to_back();
        int t0 = -1, t1 = -1; logic [2:0] after0 = 3'b111;
        cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (t0 >= 0 && t == t0 + 1) after0 = {owner, cpu_done};
            if (cpu_done) begin
                if (t0 < 0) t0 = t; else begin t1 = t; break; end
            end
        end
        @(posedge clk); #1 cpu_req = 0;
        checks++;
        if (t0 != 3 || t1 != 7) begin
            failures++; $display("FAIL back_to_back: got done at %0d,%0d want 3,7", t0, t1);
        end
        checks++;
        if (after0 !== 3'b000) begin
            failures++; $display("FAIL b2b_idle_after_done: got owner/done=%b want 000", after0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; bit er, sok; int lat; bit seen = 0; logic [1:0] s; logic [9:0] a;
        cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D; cpu_req = 1;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b1) begin
            failures++; $display("FAIL rstmid_issue: got ram_we=%b want 1", ram_we);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({ram_we, ram_re, owner, cpu_done, cpu_err} !== 6'h0 || {ram_addr, ram_wdata} !== 42'h0) begin
            failures++; $display("FAIL rstmid_async: got we=%b owner=%b addr=%h wdata=%h want all 0",
                ram_we, owner, ram_addr, ram_wdata);
        end
        cpu_req = 0;
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_done) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_done: got done=%b want 0", seen);
        end
        @(posedge clk); #1;
        run_txn(0, 0, 32'h10, 32'h0, rd, er, lat, sok, s, a);
        checks++;
        if (lat != 3 || rd !== gold[4]) begin
            failures++; $display("FAIL rstmid_recover: got lat=%0d rd=%h want 3 %h", lat, rd, gold[4]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp_cpu, exp_dbg; bit er, sok, dbg, we, exp_err;
        int lat, kind, idx; logic [1:0] s; logic [9:0] a;
        apply_reset();
        exp_cpu = 0; exp_dbg = 0;
        for (int i = 0; i < 40; i++) begin
            dbg  = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 7);
            idx  = $urandom_range(256, RAM_DEPTH - 1);
            wd   = $urandom;
            if (kind == 0)      addr = 32'(idx * 4 + $urandom_range(1, 3));
            else if (kind == 1) addr = 32'h1000 + 32'($urandom_range(0, 4095) * 4);
            else                addr = 32'(idx * 4);
            we = (kind < 2) ? 1'($urandom_range(0, 1)) : (1'($urandom_range(0, 1)) || !gvalid[idx]);
            exp_err = (addr[1:0] != 2'b00) || (addr >= 32'(4 * RAM_DEPTH));
            run_txn(dbg, we, addr, wd, rd, er, lat, sok, s, a);
            if (!exp_err) begin
                if (we) begin gold[idx] = wd; gvalid[idx] = 1; end
                else if (dbg) exp_dbg = gold[idx];
                else exp_cpu = gold[idx];
            end
            checks++;
            if (er !== exp_err || lat != 3 || cpu_rdata !== exp_cpu || dbg_rdata !== exp_dbg) begin
                failures++; $display("FAIL rand%0d: got err=%b lat=%0d cpu=%h dbg=%h want %b 3 %h %h",
                    i, er, lat, cpu_rdata, dbg_rdata, exp_err, exp_cpu, exp_dbg);
            end
        end
    endtask

    initial begin
        foreach (gvalid[i]) gvalid[i] = 0;
        test_reset();
        test_dbg_load();
        test_store_load();
        test_errors();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        checks++;
        if (proto_viol != 0 || both_strobe != 0) begin
            failures++; $display("FAIL protocol: got violations=%0d dual_strobes=%0d want 0 0",
                proto_viol, both_strobe);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
